// File: rtl/mtimer_unit_if.sv
// Bus interface for the machine timer: single-cycle request, ack one cycle
// later, plus the timer interrupt level.
interface mtimer_unit_if;
  logic        req_i;
  logic        we_i;
  logic [4:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        int_timer_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o, int_timer_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o, int_timer_o
  );
endinterface

// File: rtl/mtimer_unit.sv
// Machine timer: 64-bit mtime counter, 64-bit mtimecmp, level interrupt
// when mtime >= mtimecmp. Optional tick prescaler enabled by defining
// MTIMER_PRESCALER_EN (mtime then advances once every PRESCALE_DIV cycles).
//
// Register map (byte offsets):
//   0x00 mtime[31:0]    0x04 mtime[63:32]
//   0x08 mtimecmp[31:0] 0x0C mtimecmp[63:32]
// Anything else (including misaligned offsets) is acked, reads 0, and
// writes are dropped.
module mtimer_unit #(
  parameter int unsigned PRESCALE_DIV = 4
) (
  input logic          clk_i,
  input logic          rst_n_i,
  mtimer_unit_if.slave bus
);

  if (PRESCALE_DIV < 2 || PRESCALE_DIV > 255) begin : g_bad_div
    $error("mtimer_unit: PRESCALE_DIV must be within 2..255");
  end

  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;

  logic        addr_ok;
  logic        wr_en;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        tick;
  logic [31:0] rd_word;

  assign addr_ok     = (bus.addr_i[1:0] == 2'b00) && (bus.addr_i <= 5'h0C);
  assign wr_en       = bus.req_i && bus.we_i && addr_ok;
  assign wr_mtime_lo = wr_en && (bus.addr_i[3:2] == 2'd0);
  assign wr_mtime_hi = wr_en && (bus.addr_i[3:2] == 2'd1);
  assign wr_cmp_lo   = wr_en && (bus.addr_i[3:2] == 2'd2);
  assign wr_cmp_hi   = wr_en && (bus.addr_i[3:2] == 2'd3);

`ifdef MTIMER_PRESCALER_EN
  logic [7:0] pre_cnt_q;

  assign tick = (pre_cnt_q == 8'(PRESCALE_DIV - 1));

  // Prescaler: counts 0..PRESCALE_DIV-1; an mtime write restarts the period.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre_cnt_q <= 8'd0;
    end else if (wr_mtime_lo || wr_mtime_hi || tick) begin
      pre_cnt_q <= 8'd0;
    end else begin
      pre_cnt_q <= pre_cnt_q + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Read mux on pre-update register values; 0 for writes and unmapped offsets.
  always_comb begin
    rd_word = 32'd0;
    if (bus.req_i && !bus.we_i && addr_ok) begin
      case (bus.addr_i[3:2])
        2'd0:    rd_word = mtime_q[31:0];
        2'd1:    rd_word = mtime_q[63:32];
        2'd2:    rd_word = mtimecmp_q[31:0];
        default: rd_word = mtimecmp_q[63:32];
      endcase
    end
  end

  // mtime: a bus write to either word wins over the tick, and the other
  // word is left untouched (no carry into/out of it that cycle).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mtime_q <= 64'd0;
    end else if (wr_mtime_lo) begin
      mtime_q[31:0] <= bus.wdata_i;
    end else if (wr_mtime_hi) begin
      mtime_q[63:32] <= bus.wdata_i;
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  // mtimecmp: word-wise writes only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mtimecmp_q <= '1;
    end else begin
      if (wr_cmp_lo) mtimecmp_q[31:0]  <= bus.wdata_i;
      if (wr_cmp_hi) mtimecmp_q[63:32] <= bus.wdata_i;
    end
  end

  // Bus response: ack follows every request by one cycle; reset drops it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.ack_o   <= 1'b0;
      bus.rdata_o <= 32'd0;
    end else begin
      bus.ack_o   <= bus.req_i;
      bus.rdata_o <= rd_word;
    end
  end

  // Interrupt level from the current registers, one cycle behind any change.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.int_timer_o <= 1'b0;
    end else begin
      bus.int_timer_o <= (mtime_q >= mtimecmp_q);
    end
  end

endmodule

// File: doc/mtimer_unit.md
MTIMER_UNIT -- requirements
Module: mtimer_unit

Interface
REQ-001 SHALL have parameter PRESCALE_DIV, default 4, giving mtime tick period in clk_i cycles when prescaler is compiled in; legal range 2..255.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_i  input  1  bus access request, valid for one cycle per access.
REQ-005 SHALL have port we_i  input  1  1 = write, 0 = read; qualified by req_i.
REQ-006 SHALL have port addr_i  input  5  byte offset: 0x00 mtime[31:0], 0x04 mtime[63:32], 0x08 mtimecmp[31:0], 0x0C mtimecmp[63:32].
REQ-007 SHALL have port wdata_i  input  32  write data.
REQ-008 SHALL have port rdata_o  output  32  read data, valid when ack_o=1.
REQ-009 SHALL have port ack_o  output  1  access completion pulse.
REQ-010 SHALL have port int_timer_o  output  1  machine timer interrupt level; drives int_timer_i of csr_ctrl.

Function
REQ-011 SHALL hold a 64-bit unsigned mtime counter and a 64-bit mtimecmp register.
REQ-012 SHALL increment mtime by 1 on each tick; 64-bit unsigned arithmetic, carry from bit 31 into bit 32 in the same cycle.
REQ-013 SHALL wrap mtime from 0xFFFF_FFFF_FFFF_FFFF to 0 with no flag or stall.
REQ-014 SHALL give a bus write to an mtime word priority over a tick in the same cycle; the written word takes wdata_i, the other word holds (no carry applied that cycle).
REQ-015 SHALL update a mtimecmp word with wdata_i on a write to its offset; other word unchanged.
REQ-016 SHALL assert ack_o exactly one cycle after each cycle with req_i=1, for reads and writes alike; back-to-back requests get back-to-back acks.
REQ-017 SHALL register rdata_o with the addressed word's value as of the request cycle (pre-update); rdata_o SHALL be 0 on write acks.
REQ-018 SHALL ignore writes to unmapped or non-word-aligned offsets (addr_i[1:0]!=0 or addr_i>0x0C), still ack them, and return rdata_o=0 for such reads.
REQ-019 SHALL register int_timer_o = (mtime >= mtimecmp), 64-bit unsigned compare, evaluated on current register values; latency one cycle from any mtime/mtimecmp change.
REQ-020 SHALL deassert int_timer_o only by mtimecmp rising above mtime or mtime being written below mtimecmp; no sticky pending state.
REQ-021 SHALL treat req_i with no address decode hit as a no-op apart from the ack.

Reset
REQ-022 SHALL, while rst_n_i=0, force mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, prescaler count=0, rdata_o=0, ack_o=0, int_timer_o=0.
REQ-023 SHALL drop any in-flight ack when reset asserts mid-access; the access is lost, not replayed.
REQ-024 SHALL resume ticking on the first rising clk_i edge after rst_n_i deasserts.

Configuration
REQ-025 SHALL use macro MTIMER_PRESCALER_EN.
REQ-026 SHALL, with MTIMER_PRESCALER_EN defined, tick mtime once every PRESCALE_DIV cycles via a counter 0..PRESCALE_DIV-1 that ticks on reaching PRESCALE_DIV-1 and reloads 0; an mtime write SHALL also reset the prescaler to 0.
REQ-027 SHALL, without MTIMER_PRESCALER_EN, tick mtime every clk_i cycle and contain no prescaler logic; PRESCALE_DIV is then unused.

Verification
REQ-028 SHALL verify reset: after rst_n_i release, read 0x08 -> 0xFFFF_FFFF, read 0x0C -> 0xFFFF_FFFF, int_timer_o=0.
REQ-029 SHALL verify carry: write mtime lo=0xFFFF_FFFE, hi=0x0000_0000, no prescaler -> 2 cycles after last write mtime hi reads 0x0000_0001.
REQ-030 SHALL verify interrupt: mtimecmp=0x0000_0000_0000_0010, mtime=0 -> int_timer_o rises exactly one cycle after mtime reaches 0x10; writing mtimecmp hi=1 clears it next cycle.
REQ-031 SHALL verify write-vs-tick priority: write mtime lo=0x100 in a tick cycle -> next read returns 0x100 (+ticks since), never 0x101 in that cycle.
REQ-032 SHALL verify prescaler (macro on, PRESCALE_DIV=4): mtime=0, 40 cycles -> mtime reads 10; macro off -> 40.
REQ-033 SHALL verify wrap and bus edge cases: mtime=all ones -> 0 after one tick; read at 0x02 and 0x14 -> ack_o one cycle later, rdata_o=0, no state change.
